hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Watches the instruction held in IF/ID, the load in EX, and branch/jump resolution.
- Drives PC write-enable, IF/ID write-enable, the ID-stage `hazard` bubble input (control unit zeroes control bits) and the IF/ID flush.
- Owns the multi-cycle mult/div occupancy counter, plus a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Resolves load-use and HI/LO hazards by stalling IF/ID, flushes IF/ID on
// taken branches/jumps, tracks mult/div occupancy and counts stall cycles.
module hazard_ctrl #(
    parameter int MD_LATENCY   = 8,   // cycles HI/LO stay busy after mult/div issues (1..255)
    parameter int FLUSH_CYCLES = 1    // flush cycles per taken branch/jump (1..15)
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic [5:0]  opCode_ID,
    input  logic [5:0]  funct_ID,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        memRead_EX,
    input  logic [4:0]  rt_EX,
    input  logic        pcSrc,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        hazard,
    output logic        mdBusy,
    output logic [1:0]  state,
    output logic [15:0] stallCycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // What the pipeline is told to do this cycle.
    typedef enum logic [1:0] {
        CL_RUN,
        CL_STALL,
        CL_FLUSH
    } out_class_t;

    localparam logic [7:0] MD_LOAD    = 8'(MD_LATENCY);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam state_t     FLUSH_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    state_t     r_state;
    state_t     w_state_nxt;
    out_class_t w_class;
    logic [3:0] r_flush_cnt;
    logic [3:0] w_flush_nxt;
    logic [7:0] r_md_cnt;
    logic [15:0] r_stall_cycles;

    logic w_md_op;
    logic w_hilo_rd;
    logic w_load_use;
    logic w_md_busy;
    logic w_md_haz;

    // Instruction decode for the hazard rules.
    assign w_md_op    = (opCode_ID == 6'd0) &&
                        (funct_ID inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    assign w_hilo_rd  = (opCode_ID == 6'd0) &&
                        (funct_ID inside {6'h10, 6'h12});
    // A load into $0 never produces a value anyone waits for.
    assign w_load_use = memRead_EX && (rt_EX != 5'd0) &&
                        ((rt_EX == rs_ID) || (rt_EX == rt_ID));
    assign w_md_busy  = (r_md_cnt != 8'd0);
    assign w_md_haz   = w_md_busy && (w_md_op || w_hilo_rd);

    // State register: FSM state and the remaining-flush counter.
    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_nxt;
        end
    end

    // Next-state logic: priority pcSrc > flush in progress > load-use > mult/div > run.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        w_class     = CL_RUN;
        w_state_nxt = ST_RUN;
        w_flush_nxt = r_flush_cnt;
        if (pcSrc) begin
            // A taken branch overrides any pending stall.
            w_class     = CL_FLUSH;
            w_flush_nxt = FLUSH_LOAD;
            w_state_nxt = FLUSH_NEXT;
        end else if ((r_state == ST_FLUSH) && (r_flush_cnt != 4'd0)) begin
            w_class     = CL_FLUSH;
            w_flush_nxt = r_flush_cnt - 4'd1;
            w_state_nxt = (r_flush_cnt == 4'd1) ? ST_RUN : ST_FLUSH;
        end else if (w_load_use || w_md_haz) begin
            w_class     = CL_STALL;
            w_state_nxt = ST_STALL;
        end
    end

    // Output decode from the cycle's class; reset forces a safe hold+flush.
    always_comb begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        hazard    = 1'b0;
        ifIdFlush = 1'b0;
        mdBusy    = w_md_busy;
        if (!reset) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            hazard    = 1'b1;
            ifIdFlush = 1'b1;
            mdBusy    = 1'b0;
        end else begin
            case (w_class)
                CL_STALL: begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    hazard    = 1'b1;
                end
                CL_FLUSH: begin
                    hazard    = 1'b1;
                    ifIdFlush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state       = r_state;
    assign stallCycles = r_stall_cycles;

    // Mult/div occupancy: reload when a mult/div actually leaves ID, else count down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= 8'd0;
        end else if (w_md_op && (w_class == CL_RUN)) begin
            r_md_cnt <= MD_LOAD;
        end else if (r_md_cnt != 8'd0) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 16'd0;
        end else if ((w_class == CL_STALL) && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

endmodule
